// File: rtl/serial_mod_detect.sv
// Serial divisibility detector: tracks the running value of a bit stream modulo DIVISOR,
// MSB-first or LSB-first, with valid qualifier, synchronous restart and a saturating bit counter.
module serial_mod_detect #(
  parameter int DIVISOR   = 5,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CW        = 16,
  localparam int RW       = ($clog2(DIVISOR) < 1) ? 1 : $clog2(DIVISOR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_valid,
  input  logic          bit_in,
  input  logic          clear,
  output logic          div_out,
  output logic [RW-1:0] rem_out,
  output logic [CW-1:0] bit_cnt,
  output logic          cnt_sat
);

  localparam logic [RW:0]   DIV_W   = (RW+1)'(DIVISOR);
  localparam logic [RW-1:0] W_ONE   = RW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] w_q, w_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic          div_q, div_d;

  logic [RW-1:0] rem_base, w_base;
  logic [CW-1:0] cnt_base;
  logic          sat_base;

  // Both operands are below DIVISOR, so one conditional subtract brings the sum back in range.
  function automatic logic [RW-1:0] mod_reduce(input logic [RW:0] s);
    logic [RW:0] t;
    t = (s >= DIV_W) ? (s - DIV_W) : s;
    return t[RW-1:0];
  endfunction

  always_comb begin
    rem_base = clear ? '0    : rem_q;
    w_base   = clear ? W_ONE : w_q;
    cnt_base = clear ? '0    : cnt_q;
    sat_base = clear ? 1'b0  : sat_q;

    rem_d = rem_base;
    w_d   = w_base;
    cnt_d = cnt_base;
    sat_d = sat_base;

    if (bit_valid) begin
      if (LSB_FIRST) begin
        rem_d = mod_reduce({1'b0, rem_base} + (bit_in ? {1'b0, w_base} : '0));
        w_d   = mod_reduce({w_base, 1'b0});
      end else begin
        rem_d = mod_reduce({rem_base, bit_in});
      end
      cnt_d = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
      sat_d = sat_base | (cnt_d == CNT_MAX);
    end

    // Taken from next-state so the flag lines up with rem_out in the same cycle.
    div_d = (rem_d == '0) && (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      w_q   <= W_ONE;
      cnt_q <= '0;
      sat_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      div_q <= div_d;
    end
  end

  assign rem_out = rem_q;
  assign bit_cnt = cnt_q;
  assign cnt_sat = sat_q;
  assign div_out = div_q;

endmodule

// File: tb/tb_serial_mod_detect.sv
// Bench for serial_mod_detect: five configurations share one stimulus stream and are checked
// against a model that keeps the whole stream value as an integer.
module tb_serial_mod_detect;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  logic        d5m, s5m, d5l, s5l, d3m, s3m, d7s, s7s, d11l, s11l;
  logic [2:0]  r5m, r5l, r7s;
  logic [1:0]  r3m;
  logic [3:0]  r11l;
  logic [15:0] c5m, c5l, c3m;
  logic [2:0]  c7s;
  logic [3:0]  c11l;

  serial_mod_detect #(.DIVISOR(5), .LSB_FIRST(1'b0), .CW(16)) u5m (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .div_out(d5m), .rem_out(r5m), .bit_cnt(c5m), .cnt_sat(s5m));
  serial_mod_detect #(.DIVISOR(5), .LSB_FIRST(1'b1), .CW(16)) u5l (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .div_out(d5l), .rem_out(r5l), .bit_cnt(c5l), .cnt_sat(s5l));
  serial_mod_detect #(.DIVISOR(3), .LSB_FIRST(1'b0), .CW(16)) u3m (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .div_out(d3m), .rem_out(r3m), .bit_cnt(c3m), .cnt_sat(s3m));
  serial_mod_detect #(.DIVISOR(7), .LSB_FIRST(1'b0), .CW(3)) u7s (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .div_out(d7s), .rem_out(r7s), .bit_cnt(c7s), .cnt_sat(s7s));
  serial_mod_detect #(.DIVISOR(11), .LSB_FIRST(1'b1), .CW(4)) u11l (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .clear(clear),
    .div_out(d11l), .rem_out(r11l), .bit_cnt(c11l), .cnt_sat(s11l));

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference: bits accepted so far and the stream value read in both orders.
  int     m_n  = 0;
  longint m_vm = 0;
  longint m_vl = 0;

  typedef struct {
    bit v;
    bit b;
    bit c;
    int rem;
    bit dv;
    int cnt;
  } vec_t;

  vec_t tbl[10];
  int   rem7[9];

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_model(input string tag, input int d, input int cw, input bit lsb,
                           input longint rem, input longint dv, input longint cnt,
                           input longint sat);
    longint v, er, mx, ec;
    v  = lsb ? m_vl : m_vm;
    er = v % d;
    mx = (longint'(1) << cw) - 1;
    ec = (m_n >= mx) ? mx : longint'(m_n);
    chk({tag, ".rem"}, rem, er);
    chk({tag, ".div"}, dv, longint'((m_n != 0) && (er == 0)));
    chk({tag, ".cnt"}, cnt, ec);
    chk({tag, ".sat"}, sat, longint'(m_n >= mx));
  endtask

  task automatic check_all();
    chk_model("d5msb", 5, 16, 1'b0, r5m, d5m, c5m, s5m);
    chk_model("d5lsb", 5, 16, 1'b1, r5l, d5l, c5l, s5l);
    chk_model("d3msb", 3, 16, 1'b0, r3m, d3m, c3m, s3m);
    chk_model("d7cw3", 7, 3, 1'b0, r7s, d7s, c7s, s7s);
    chk_model("d11lsb", 11, 4, 1'b1, r11l, d11l, c11l, s11l);
  endtask

  task automatic model_zero();
    m_n = 0; m_vm = 0; m_vl = 0;
  endtask

  task automatic model_update();
    if (clear) model_zero();
    if (bit_valid) begin
      m_vm = 2 * m_vm + longint'(bit_in);
      m_vl = m_vl + (longint'(bit_in) << m_n);
      m_n++;
    end
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    bit_valid = v; bit_in = b; clear = c;
    @(posedge clk);
    #1;
    model_update();
    check_all();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 2};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 3};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 2};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 3};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 4};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 4};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 4};
    rem7 = '{1, 3, 0, 1, 3, 0, 1, 3, 0};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    model_zero();
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // MSB-first divide-by-5 directed table, including hold on idle cycles
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].b, tbl[i].c);
      chk($sformatf("tbl%0d.rem", i), r5m, tbl[i].rem);
      chk($sformatf("tbl%0d.div", i), d5m, tbl[i].dv);
      chk($sformatf("tbl%0d.cnt", i), c5m, tbl[i].cnt);
    end

    // LSB-first: bits 1,0,1,1 give values 1,1,5,13
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0); chk("lsb.b0.rem", r5l, 1); chk("lsb.b0.div", d5l, 0);
    step(1'b1, 1'b0, 1'b0); chk("lsb.b1.rem", r5l, 1); chk("lsb.b1.div", d5l, 0);
    step(1'b1, 1'b1, 1'b0); chk("lsb.b2.rem", r5l, 0); chk("lsb.b2.div", d5l, 1);
    step(1'b1, 1'b1, 1'b0); chk("lsb.b3.rem", r5l, 3); chk("lsb.b3.div", d5l, 0);

    // Divide-by-3 with clear coinciding with an accepted bit
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("d3.pre.div", d3m, 1);
    step(1'b1, 1'b1, 1'b1);
    chk("d3.clr.rem", r3m, 1); chk("d3.clr.cnt", c3m, 1); chk("d3.clr.div", d3m, 0);
    step(1'b1, 1'b0, 1'b0); chk("d3.end.rem", r3m, 2); chk("d3.end.div", d3m, 0);

    // Asynchronous reset mid-stream, observed before the next clock edge
    step(1'b1, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
    #1;
    model_zero();
    check_all();
    chk("arst.rem", r5m, 0); chk("arst.cnt", c5m, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0); chk("arst.b0.div", d5m, 1); chk("arst.b0.cnt", c5m, 1);
    step(1'b1, 1'b0, 1'b0);
    chk("arst.b1.rem", r5m, 0); chk("arst.b1.div", d5m, 1); chk("arst.b1.cnt", c5m, 2);

    // 3-bit counter saturation with divide-by-7 on an all-ones stream
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b1, 1'b0);
      chk($sformatf("sat%0d.rem", k), r7s, rem7[k-1]);
      chk($sformatf("sat%0d.cnt", k), c7s, (k < 7) ? k : 7);
      chk($sformatf("sat%0d.flag", k), s7s, (k >= 7) ? 1 : 0);
      chk($sformatf("sat%0d.div", k), d7s, (k % 3 == 0) ? 1 : 0);
    end

    // Random streams with sporadic clears, kept short enough for exact 64-bit values
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 29) == 0) || (m_n >= 56));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
